break_eval_sequencer: RTL and testbench

- Controller stage directly upstream of the break-value counter/selector.
- Latches the NSAT variable indices of the chosen unsatisfied clause and fetches each variable's clause-occurrence mask from the per-variable mask RAM.
- Drives the selector's one-hot / all-ones write-enable code and the candidate valid bits, then samples the selector's choice.
- Emits the selected variable index to the flip unit with a one-cycle done pulse.

---
 rtl/break_eval_sequencer.sv | 114 +++++++++++
 tb/tb_break_eval_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/break_eval_sequencer.sv
// Break-value evaluation sequencer: fetches candidate masks, steps the
// selector through its write enables and captures the chosen flip variable.
module break_eval_sequencer #(
  parameter int NSAT        = 3,
  parameter int NUM_CLAUSES = 20,
  parameter int NUM_VARS    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic [NSAT*$clog2(NUM_VARS)-1:0] var_idx_i,
  input  logic [NSAT-1:0]              cand_valid_i,
  output logic [$clog2(NUM_VARS)-1:0]  mask_addr_o,
  output logic                         mask_rd_o,
  input  logic [NUM_CLAUSES-1:0]       mask_data_i,
  output logic [NUM_CLAUSES-1:0]       mask_bits_o,
  output logic [1:0]                   wren_o,
  output logic [NSAT-1:0]              break_valid_o,
  input  logic [1:0]                   select_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [$clog2(NUM_VARS)-1:0]  flip_var_o,
  output logic                         no_cand_o
);

  localparam int VB = $clog2(NUM_VARS);

  typedef enum logic [2:0] {
    IDLE, RD0, EV0, EV1, EV2, CAP, DONE
  } state_t;

  state_t              state;
  logic [NSAT*VB-1:0]  var_q;
  logic [VB-1:0]       sel_var;

  assign mask_bits_o = mask_data_i;

  // Out-of-range choice falls back to slot 0; no_cand_o flags it.
  always_comb begin
    sel_var = var_q[0 +: VB];
    unique case (select_i)
      2'd1:    sel_var = var_q[VB +: VB];
      2'd2:    sel_var = var_q[2*VB +: VB];
      default: sel_var = var_q[0 +: VB];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      var_q         <= '0;
      break_valid_o <= '0;
      mask_addr_o   <= '0;
      mask_rd_o     <= 1'b0;
      wren_o        <= 2'b00;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      flip_var_o    <= '0;
      no_cand_o     <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      mask_rd_o <= 1'b0;
      wren_o    <= 2'b00;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            var_q         <= var_idx_i;
            break_valid_o <= cand_valid_i;
            busy_o        <= 1'b1;
            if (cand_valid_i == '0) begin
              state     <= DONE;
              done_o    <= 1'b1;
              no_cand_o <= 1'b1;
            end else begin
              state       <= RD0;
              mask_rd_o   <= 1'b1;
              mask_addr_o <= var_idx_i[0 +: VB];
            end
          end
        end
        RD0: begin
          state       <= EV0;
          wren_o      <= 2'b01;
          mask_rd_o   <= 1'b1;
          mask_addr_o <= var_q[VB +: VB];
        end
        EV0: begin
          state       <= EV1;
          wren_o      <= 2'b10;
          mask_rd_o   <= 1'b1;
          mask_addr_o <= var_q[2*VB +: VB];
        end
        EV1: begin
          state  <= EV2;
          wren_o <= 2'b11;
        end
        EV2: state <= CAP;
        CAP: begin
          state      <= DONE;
          flip_var_o <= sel_var;
          no_cand_o  <= (select_i == 2'd3);
          done_o     <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          busy_o    <= 1'b0;
          no_cand_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_break_eval_sequencer.sv
// Directed bench for break_eval_sequencer with a one-cycle-latency mask RAM.
module tb_break_eval_sequencer;

  localparam int VB = 6;
  localparam int NC = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [3*VB-1:0] var_idx_i;
  logic [2:0]    cand_valid_i;
  logic [VB-1:0] mask_addr_o;
  logic          mask_rd_o;
  logic [NC-1:0] mask_data_i;
  logic [NC-1:0] mask_bits_o;
  logic [1:0]    wren_o;
  logic [2:0]    break_valid_o;
  logic [1:0]    select_i;
  logic          busy_o;
  logic          done_o;
  logic [VB-1:0] flip_var_o;
  logic          no_cand_o;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int done_cnt;
  int rd_base;

  logic [NC-1:0] mem [64];

  break_eval_sequencer #(.NSAT(3), .NUM_CLAUSES(NC), .NUM_VARS(64)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .var_idx_i(var_idx_i), .cand_valid_i(cand_valid_i),
    .mask_addr_o(mask_addr_o), .mask_rd_o(mask_rd_o),
    .mask_data_i(mask_data_i), .mask_bits_o(mask_bits_o),
    .wren_o(wren_o), .break_valid_o(break_valid_o),
    .select_i(select_i), .busy_o(busy_o), .done_o(done_o),
    .flip_var_o(flip_var_o), .no_cand_o(no_cand_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mask_rd_o) begin
      mask_data_i <= mem[mask_addr_o];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [VB-1:0] v0, input logic [VB-1:0] v1,
                    input logic [VB-1:0] v2, input logic [2:0] val);
    var_idx_i    = {v2, v1, v0};
    cand_valid_i = val;
    start_i      = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[5]  = 20'h12345;
    mem[9]  = 20'hABCDE;
    mem[12] = 20'h0F0F0;
    mask_data_i  = '0;
    reset        = 1'b1;
    start_i      = 1'b0;
    var_idx_i    = '0;
    cand_valid_i = '0;
    select_i     = 2'd0;
    step(); step(); step();
    reset = 1'b0;

    chk("rst_wren", 32'(wren_o), 0);
    chk("rst_rd", 32'(mask_rd_o), 0);
    chk("rst_addr", 32'(mask_addr_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_flip", 32'(flip_var_o), 0);
    chk("rst_nocand", 32'(no_cand_o), 0);
    chk("rst_bvalid", 32'(break_valid_o), 0);

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_wren", 32'(wren_o), 0);
      chk("idle_rd", 32'(mask_rd_o), 0);
      chk("idle_done", 32'(done_o), 0);
    end

    // full evaluation, vars {5,9,12}, select 1
    go(6'd5, 6'd9, 6'd12, 3'b111);
    step(); start_i = 1'b0;
    chk("c1_addr", 32'(mask_addr_o), 5);
    chk("c1_rd", 32'(mask_rd_o), 1);
    chk("c1_wren", 32'(wren_o), 0);
    chk("c1_busy", 32'(busy_o), 1);
    step();
    chk("c2_addr", 32'(mask_addr_o), 9);
    chk("c2_wren", 32'(wren_o), 1);
    chk("c2_mask", 32'(mask_bits_o), 32'h12345);
    chk("c2_bvalid", 32'(break_valid_o), 3'b111);
    step();
    chk("c3_addr", 32'(mask_addr_o), 12);
    chk("c3_wren", 32'(wren_o), 2);
    chk("c3_mask", 32'(mask_bits_o), 32'hABCDE);
    step();
    chk("c4_wren", 32'(wren_o), 3);
    chk("c4_rd", 32'(mask_rd_o), 0);
    chk("c4_mask", 32'(mask_bits_o), 32'h0F0F0);
    step();
    select_i = 2'd1;
    chk("c5_wren", 32'(wren_o), 0);
    chk("c5_done", 32'(done_o), 0);
    step();
    chk("c6_done", 32'(done_o), 1);
    chk("c6_flip", 32'(flip_var_o), 9);
    chk("c6_nocand", 32'(no_cand_o), 0);
    chk("c6_busy", 32'(busy_o), 1);
    step();
    chk("c7_done", 32'(done_o), 0);
    chk("c7_busy", 32'(busy_o), 0);

    // no valid candidates
    rd_base = rd_cnt;
    go(6'd1, 6'd2, 6'd3, 3'b000);
    step(); start_i = 1'b0;
    chk("nc_done", 32'(done_o), 1);
    chk("nc_flag", 32'(no_cand_o), 1);
    chk("nc_wren", 32'(wren_o), 0);
    chk("nc_rd", 32'(mask_rd_o), 0);
    step();
    chk("nc_done_off", 32'(done_o), 0);
    chk("nc_wren2", 32'(wren_o), 0);
    chk("nc_reads", 32'(rd_cnt - rd_base), 0);

    // start pulses while busy are dropped; start in cycle 7 is taken
    step();
    select_i = 2'd0;
    go(6'd21, 6'd22, 6'd23, 3'b111);
    done_cnt = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      start_i = (c == 2 || c == 4 || c == 6 || c == 7);
      if (done_o) done_cnt++;
      chk("b2b_done", 32'(done_o), 32'(c == 6 || c == 13));
      if (c == 13) chk("b2b_flip", 32'(flip_var_o), 21);
    end
    start_i = 1'b0;
    chk("b2b_count", 32'(done_cnt), 2);

    // reset in EV1
    step();
    go(6'd5, 6'd9, 6'd12, 3'b111);
    step(); start_i = 1'b0;
    step(); step();
    chk("ev1_wren", 32'(wren_o), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_ev1_wren", 32'(wren_o), 0);
    chk("rst_ev1_busy", 32'(busy_o), 0);
    chk("rst_ev1_rd", 32'(mask_rd_o), 0);
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (done_o) done_cnt++;
      step();
    end
    chk("rst_ev1_nodone", 32'(done_cnt), 0);

    // valid 101, select 2
    go(6'd7, 6'd33, 6'd40, 3'b101);
    step(); start_i = 1'b0;
    step();
    chk("v101_bv_ev0", 32'(break_valid_o), 3'b101);
    step();
    chk("v101_bv_ev1", 32'(break_valid_o), 3'b101);
    step();
    chk("v101_bv_ev2", 32'(break_valid_o), 3'b101);
    step();
    select_i = 2'd2;
    step();
    chk("v101_done", 32'(done_o), 1);
    chk("v101_flip", 32'(flip_var_o), 40);
    chk("v101_nocand", 32'(no_cand_o), 0);

    // out-of-range select falls back to slot 0
    step();
    go(6'd17, 6'd18, 6'd19, 3'b011);
    for (int c = 1; c <= 6; c++) begin
      step();
      start_i = 1'b0;
      if (c == 5) select_i = 2'd3;
    end
    chk("sel3_done", 32'(done_o), 1);
    chk("sel3_flip", 32'(flip_var_o), 17);
    chk("sel3_nocand", 32'(no_cand_o), 1);
    step();
    chk("sel3_clear", 32'(no_cand_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
